// File: rtl/alu_seq_pkg.sv
// Shared opcodes and FSM state encoding for the sequential N-bit ALU.
package alu_seq_pkg;

  typedef logic [2:0] op_e;

  localparam op_e OP_CMP = 3'b000;
  localparam op_e OP_SUB = 3'b001;
  localparam op_e OP_ROL = 3'b010;
  localparam op_e OP_ADD = 3'b011;
  localparam op_e OP_ROR = 3'b100;
  localparam op_e OP_MUL = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

endpackage

// File: rtl/alu_rot_step.sv
// Combinational single-bit rotate; o_result = {bit rotated out, rotated data}.
module alu_rot_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_left,
  output logic [WIDTH:0]   o_result
);

  // Left sends the MSB round to bit 0; right sends the LSB round to the MSB.
  always_comb begin
    if (i_left) begin
      o_result = {i_data[WIDTH-1], i_data[WIDTH-2:0], i_data[WIDTH-1]};
    end else begin
      o_result = {i_data[0], i_data[0], i_data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Handshaked multi-cycle ALU: ADD/SUB/CMP in one EXEC cycle, rotates one bit per cycle.
// Optional shift-add multiplier on op 101 when ALU_SEQ_MUL_EN is defined.
module alu_seq_nbit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             cf,
  output logic             sf,
  output logic             zf,
  output logic             of
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH[WIDTH-1:0];

  state_e           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  op_e              r_op;
  logic [CNT_W-1:0] r_cnt, w_k;
  logic             r_rcf;
  logic             r_cf, r_sf, r_zf, r_of;

  logic             w_sub, w_is_rot, w_exec_done, w_of;
  logic [WIDTH-1:0] w_bop;
  logic [WIDTH:0]   w_sum, w_rot;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] r_prod, w_prod_nxt;
  logic [WIDTH:0]     w_mul_hi;
`endif

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign r  = r_res;
  assign cf = r_cf;
  assign sf = r_sf;
  assign zf = r_zf;
  assign of = r_of;

  assign w_k      = CNT_W'(b % WIDTH_V);
  assign w_is_rot = (r_op == OP_ROL) || (r_op == OP_ROR);

  // Shared WIDTH+1 adder: ADD uses b, SUB/CMP use ~b with carry-in 1.
  always_comb begin
    w_sub = (r_op != OP_ADD);
    w_bop = w_sub ? ~r_b : r_b;
    w_sum = {1'b0, r_a} + {1'b0, w_bop} + {{WIDTH{1'b0}}, w_sub};
    w_of  = (r_a[WIDTH-1] == w_bop[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
  end

  alu_rot_step #(
    .WIDTH(WIDTH)
  ) u_rot (
    .i_data  (r_a),
    .i_left  (r_op == OP_ROL),
    .o_result(w_rot)
  );

`ifdef ALU_SEQ_MUL_EN
  // One shift-add step: add multiplicand to the high half on multiplier LSB, then shift right.
  always_comb begin
    w_mul_hi   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_a} : '0);
    w_prod_nxt = {w_mul_hi, r_prod[WIDTH-1:1]};
  end
`endif

  // Iterative ops stay in EXEC until their counter has reached zero.
  always_comb begin
    w_exec_done = 1'b1;
    if (w_is_rot && (r_cnt != '0)) w_exec_done = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    if ((r_op == OP_MUL) && (r_cnt != '0)) w_exec_done = 1'b0;
`endif
  end

  // FSM next-state: IDLE -> EXEC on accept, EXEC -> DONE when finished, DONE -> IDLE on take.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = EXEC;
      EXEC:    if (w_exec_done) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath: operand capture, iteration and registered result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= OP_CMP;
      r_cnt <= '0;
      r_rcf <= 1'b0;
      r_res <= '0;
      r_cf  <= 1'b0;
      r_sf  <= 1'b0;
      r_zf  <= 1'b0;
      r_of  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      r_prod <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_rcf <= 1'b0;
            r_cnt <= '0;
            if ((op == OP_ROL) || (op == OP_ROR)) r_cnt <= w_k;
`ifdef ALU_SEQ_MUL_EN
            if (op == OP_MUL) begin
              r_cnt  <= CNT_W'(WIDTH - 1);
              r_prod <= {{WIDTH{1'b0}}, b};
            end
`endif
          end
        end
        EXEC: begin
          case (r_op)
            OP_ROL, OP_ROR: begin
              if (r_cnt == '0) begin
                r_res <= r_a;
                r_cf  <= r_rcf;
                r_of  <= 1'b0;
                r_sf  <= r_a[WIDTH-1];
                r_zf  <= (r_a == '0);
              end else begin
                r_a   <= w_rot[WIDTH-1:0];
                r_rcf <= w_rot[WIDTH];
                r_cnt <= r_cnt - 1'b1;
              end
            end
            OP_ADD, OP_SUB: begin
              r_res <= w_sum[WIDTH-1:0];
              r_cf  <= w_sum[WIDTH];
              r_of  <= w_of;
              r_sf  <= w_sum[WIDTH-1];
              r_zf  <= (w_sum[WIDTH-1:0] == '0);
            end
            // Flags only; the previous result is kept.
            OP_CMP: begin
              r_cf <= w_sum[WIDTH];
              r_of <= w_of;
              r_sf <= w_sum[WIDTH-1];
              r_zf <= (w_sum[WIDTH-1:0] == '0);
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              r_prod <= w_prod_nxt;
              r_cnt  <= r_cnt - 1'b1;
              if (r_cnt == '0) begin
                r_res <= w_prod_nxt[WIDTH-1:0];
                r_cf  <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                r_of  <= |w_prod_nxt[2*WIDTH-1:WIDTH];
                r_sf  <= w_prod_nxt[WIDTH-1];
                r_zf  <= (w_prod_nxt[WIDTH-1:0] == '0);
              end
            end
`endif
            default: begin
              r_res <= '0;
              r_cf  <= 1'b0;
              r_sf  <= 1'b0;
              r_zf  <= 1'b1;
              r_of  <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
